eth_rx_hdr_parser: RTL and testbench
====================================

ETH_RX_HDR_PARSER -- requirements
Module: eth_rx_hdr_parser

Interface
REQ-001 Parameters: none; header length is fixed at 14 bytes.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_axis_tdata  input  8  received byte from MAC RX stream (no backpressure).
REQ-005 s_axis_tvalid  input  1  byte valid.
REQ-006 s_axis_tlast  input  1  last byte of frame.
REQ-007 s_axis_tuser  input  1  bad frame/FCS flag, valid with tlast.
REQ-008 m_hdr_valid  output  1  one-cycle pulse: header fields valid, frame accepted.
REQ-009 m_eth_dest_mac  output  48  destination MAC; first received byte in [47:40].
REQ-010 m_eth_src_mac  output  48  source MAC, same byte order.
REQ-011 m_eth_type  output  16  EtherType; byte 12 in [15:8].
REQ-012 m_payload_tdata / m_payload_tvalid / m_payload_tlast / m_payload_tuser  output  8/1/1/1  payload stream (no tready).
REQ-013 cfg_local_mac  input  48  station address.
REQ-014 cfg_promisc  input  1  accept all destinations.
REQ-015 cfg_multicast_enable  input  1  accept group addresses.
REQ-016 error_header_early_termination  output  1  one-cycle pulse.
REQ-017 rx_frame_dropped  output  1  one-cycle pulse, frame rejected by address filter.

Function
REQ-018 States: IDLE, HDR, PAYLOAD, DROP; 4-bit header byte counter 0..13.
REQ-019 IDLE: first valid beat is header byte 0; counter <= 1, go HDR.
REQ-020 HDR: each valid beat shifts into dest/src/type registers per counter index; header field outputs update only with m_hdr_valid.
REQ-021 Valid beat with tlast at header index 0..13: error_header_early_termination pulses next cycle; no m_hdr_valid; go IDLE.
REQ-022 Byte 13 without tlast: evaluate filter on completed header; cfg_* sampled this cycle only.
REQ-023 Accept if cfg_promisc, or dest == cfg_local_mac, or dest == FF:FF:FF:FF:FF:FF, or (cfg_multicast_enable and dest[40]).
REQ-024 Accept: m_hdr_valid and header outputs asserted the cycle after byte 13; go PAYLOAD.
REQ-025 Reject: rx_frame_dropped pulses the cycle after byte 13; go DROP.
REQ-026 PAYLOAD: each valid input beat appears on m_payload_* exactly 1 cycle later; tlast/tuser pass through; m_payload_tvalid low on idle cycles.
REQ-027 PAYLOAD tlast beat: go IDLE; the next cycle's valid beat is byte 0 of a new frame (back-to-back supported).
REQ-028 DROP: discard all beats through tlast, no outputs; then IDLE.
REQ-029 tvalid low in any state: no state or counter change.
REQ-030 Header field outputs hold their value until the next m_hdr_valid.

Reset
REQ-031 rst asserted: state IDLE, counter 0, all outputs and header registers 0, immediately (asynchronous).
REQ-032 Reset mid-frame: remainder of that frame after release is parsed as a new frame from byte 0; no error pulses for the aborted frame.

Structure
REQ-033 Shared package eth_pkg: state enum, ETH_HDR_LEN = 14, ETH_BCAST_MAC constant.
REQ-034 One combinational sub-module natural: eth_addr_match (dest, local mac, cfg bits -> accept).

Verification
REQ-035 Dest = cfg_local_mac 02:00:00:00:00:01, type 0x0800, 46-byte payload -> m_hdr_valid one cycle after byte 13, 46 payload beats at 1-cycle latency, tlast on last.
REQ-036 Dest 02:00:00:00:00:99, promisc 0 -> rx_frame_dropped once, no payload beats; same frame with promisc 1 -> accepted.
REQ-037 Dest 01:00:5E:00:00:01 with multicast_enable 0 -> dropped; with 1 -> accepted; dest FF:FF:FF:FF:FF:FF -> always accepted.
REQ-038 10-byte frame with tlast on byte 9, then 14-byte frame ending at byte 13 -> two error_header_early_termination pulses, no m_hdr_valid.
REQ-039 Two back-to-back accepted frames, second with tuser=1 on tlast -> two m_hdr_valid pulses, m_payload_tuser=1 only on second frame's last beat.
REQ-040 rst asserted at payload byte 5 -> outputs 0 immediately; after release, trailing bytes are parsed as a new frame.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the Ethernet RX header parser
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } eth_state_e;

    localparam int          ETH_HDR_LEN   = 14;
    localparam logic [3:0]  ETH_HDR_LAST  = 4'(ETH_HDR_LEN - 1);
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_addr_match.sv
// rtl/eth_addr_match.sv - destination address filter (combinational)
module eth_addr_match
    import eth_pkg::*;
(
    input  logic [47:0] dest_mac_i,
    input  logic [47:0] local_mac_i,
    input  logic        promisc_i,
    input  logic        multicast_enable_i,
    output logic        accept_o
);

    // Bit 40 is the I/G bit of the first transmitted octet: set for group addresses.
    assign accept_o = promisc_i
                   || (dest_mac_i == local_mac_i)
                   || (dest_mac_i == ETH_BCAST_MAC)
                   || (multicast_enable_i && dest_mac_i[40]);

endmodule

// File: rtl/eth_rx_hdr_parser.sv
// rtl/eth_rx_hdr_parser.sv - strips the 14-byte Ethernet header, filters by destination, forwards payload
module eth_rx_hdr_parser
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_hdr_valid,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [7:0]  m_payload_tdata,
    output logic        m_payload_tvalid,
    output logic        m_payload_tlast,
    output logic        m_payload_tuser,
    input  logic [47:0] cfg_local_mac,
    input  logic        cfg_promisc,
    input  logic        cfg_multicast_enable,
    output logic        error_header_early_termination,
    output logic        rx_frame_dropped
);

    eth_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [103:0] hdr_q, hdr_d;
    logic [111:0] hdr_full;
    logic         accept;

    logic         hdr_valid_q, hdr_valid_d;
    logic [47:0]  dest_q, dest_d;
    logic [47:0]  src_q, src_d;
    logic [15:0]  type_q, type_d;
    logic [7:0]   pl_tdata_q, pl_tdata_d;
    logic         pl_tvalid_q, pl_tvalid_d;
    logic         pl_tlast_q, pl_tlast_d;
    logic         pl_tuser_q, pl_tuser_d;
    logic         err_q, err_d;
    logic         drop_q, drop_d;

    // Header as it stands including the byte on the bus this cycle.
    assign hdr_full = {hdr_q, s_axis_tdata};

    eth_addr_match u_addr_match (
        .dest_mac_i         (hdr_full[111:64]),
        .local_mac_i        (cfg_local_mac),
        .promisc_i          (cfg_promisc),
        .multicast_enable_i (cfg_multicast_enable),
        .accept_o           (accept)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        dest_d      = dest_q;
        src_d       = src_q;
        type_d      = type_q;
        pl_tdata_d  = pl_tdata_q;
        pl_tvalid_d = 1'b0;
        pl_tlast_d  = 1'b0;
        pl_tuser_d  = 1'b0;
        err_d       = 1'b0;
        drop_d      = 1'b0;

        if (s_axis_tvalid) begin
            unique case (state_q)
                ST_IDLE: begin
                    hdr_d = hdr_full[103:0];
                    if (s_axis_tlast) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    hdr_d = hdr_full[103:0];
                    if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else if (cnt_q == ETH_HDR_LAST) begin
                        cnt_d = 4'd0;
                        if (accept) begin
                            hdr_valid_d = 1'b1;
                            dest_d      = hdr_full[111:64];
                            src_d       = hdr_full[63:16];
                            type_d      = hdr_full[15:0];
                            state_d     = ST_PAYLOAD;
                        end else begin
                            drop_d  = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_PAYLOAD: begin
                    pl_tvalid_d = 1'b1;
                    pl_tdata_d  = s_axis_tdata;
                    pl_tlast_d  = s_axis_tlast;
                    pl_tuser_d  = s_axis_tuser;
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
                ST_DROP: begin
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            dest_q      <= '0;
            src_q       <= '0;
            type_q      <= '0;
            pl_tdata_q  <= '0;
            pl_tvalid_q <= 1'b0;
            pl_tlast_q  <= 1'b0;
            pl_tuser_q  <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            pl_tdata_q  <= pl_tdata_d;
            pl_tvalid_q <= pl_tvalid_d;
            pl_tlast_q  <= pl_tlast_d;
            pl_tuser_q  <= pl_tuser_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign m_hdr_valid                    = hdr_valid_q;
    assign m_eth_dest_mac                 = dest_q;
    assign m_eth_src_mac                  = src_q;
    assign m_eth_type                     = type_q;
    assign m_payload_tdata                = pl_tdata_q;
    assign m_payload_tvalid               = pl_tvalid_q;
    assign m_payload_tlast                = pl_tlast_q;
    assign m_payload_tuser                = pl_tuser_q;
    assign error_header_early_termination = err_q;
    assign rx_frame_dropped               = drop_q;

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// tb/tb_eth_rx_hdr_parser.sv - scoreboard bench for eth_rx_hdr_parser
module tb_eth_rx_hdr_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        m_hdr_valid;
    logic [47:0] m_eth_dest_mac;
    logic [47:0] m_eth_src_mac;
    logic [15:0] m_eth_type;
    logic [7:0]  m_payload_tdata;
    logic        m_payload_tvalid;
    logic        m_payload_tlast;
    logic        m_payload_tuser;
    logic [47:0] cfg_local_mac;
    logic        cfg_promisc;
    logic        cfg_multicast_enable;
    logic        error_header_early_termination;
    logic        rx_frame_dropped;

    typedef struct {
        int          cyc;
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
    } hdr_exp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  data;
        logic        last;
        logic        user;
    } pl_exp_t;

    hdr_exp_t exp_hdr[$];
    pl_exp_t  exp_pl[$];
    int       exp_err[$];
    int       exp_drop[$];

    hdr_exp_t he;
    pl_exp_t  pe;
    int       ec;
    int       cyc = 0;
    int       total = 0;
    int       bad = 0;
    logic [47:0] last_dest;
    logic [47:0] last_src;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] MCAST_MAC = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC_A     = 48'h02_11_22_33_44_55;
    localparam logic [47:0] SRC_B     = 48'h0A_BC_DE_F0_12_34;

    eth_rx_hdr_parser dut (
        .clk                            (clk),
        .rst                            (rst),
        .s_axis_tdata                   (s_axis_tdata),
        .s_axis_tvalid                  (s_axis_tvalid),
        .s_axis_tlast                   (s_axis_tlast),
        .s_axis_tuser                   (s_axis_tuser),
        .m_hdr_valid                    (m_hdr_valid),
        .m_eth_dest_mac                 (m_eth_dest_mac),
        .m_eth_src_mac                  (m_eth_src_mac),
        .m_eth_type                     (m_eth_type),
        .m_payload_tdata                (m_payload_tdata),
        .m_payload_tvalid               (m_payload_tvalid),
        .m_payload_tlast                (m_payload_tlast),
        .m_payload_tuser                (m_payload_tuser),
        .cfg_local_mac                  (cfg_local_mac),
        .cfg_promisc                    (cfg_promisc),
        .cfg_multicast_enable           (cfg_multicast_enable),
        .error_header_early_termination (error_header_early_termination),
        .rx_frame_dropped               (rx_frame_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every DUT output event must match the oldest expectation, on the expected cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (m_hdr_valid === 1'b1) begin
                chk("hdr_expected", 64'(exp_hdr.size() > 0), 64'd1);
                if (exp_hdr.size() > 0) begin
                    he = exp_hdr.pop_front();
                    chk("hdr_cycle", 64'(cyc), 64'(he.cyc));
                    chk("hdr_dest", 64'(m_eth_dest_mac), 64'(he.dest));
                    chk("hdr_src", 64'(m_eth_src_mac), 64'(he.src));
                    chk("hdr_type", 64'(m_eth_type), 64'(he.etype));
                end
            end
            if (m_payload_tvalid === 1'b1) begin
                chk("pl_expected", 64'(exp_pl.size() > 0), 64'd1);
                if (exp_pl.size() > 0) begin
                    pe = exp_pl.pop_front();
                    chk("pl_cycle", 64'(cyc), 64'(pe.cyc));
                    chk("pl_data", 64'(m_payload_tdata), 64'(pe.data));
                    chk("pl_last", 64'(m_payload_tlast), 64'(pe.last));
                    chk("pl_user", 64'(m_payload_tuser), 64'(pe.user));
                end
            end
            if (error_header_early_termination === 1'b1) begin
                chk("err_expected", 64'(exp_err.size() > 0), 64'd1);
                if (exp_err.size() > 0) begin
                    ec = exp_err.pop_front();
                    chk("err_cycle", 64'(cyc), 64'(ec));
                end
            end
            if (rx_frame_dropped === 1'b1) begin
                chk("drop_expected", 64'(exp_drop.size() > 0), 64'd1);
                if (exp_drop.size() > 0) begin
                    ec = exp_drop.pop_front();
                    chk("drop_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
        @(posedge clk);
        #1;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int npay, input logic last_user, input bit acc,
                              input bit gaps, input bit no_last, input logic [7:0] seed);
        logic [111:0] h;
        logic [7:0]   b;
        logic         l;
        logic         u;
        h = {d, s, t};
        for (int i = 0; i < 14; i++) begin
            if (gaps && i == 7) idle(1);
            send_byte(h[111 - 8*i -: 8], 1'b0, 1'b0);
        end
        if (acc) begin
            exp_hdr.push_back('{cyc + 1, d, s, t});
            last_dest = d;
            last_src  = s;
        end else begin
            exp_drop.push_back(cyc + 1);
        end
        for (int p = 0; p < npay; p++) begin
            if (gaps && p == 2) idle(1);
            b = 8'(p * 7) + seed;
            l = !no_last && (p == npay - 1);
            u = l && last_user;
            send_byte(b, l, u);
            if (acc) exp_pl.push_back('{cyc + 1, b, l, u});
        end
    endtask

    task automatic send_short(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            send_byte(seed + 8'(i), i == n - 1, 1'b0);
        end
        exp_err.push_back(cyc + 1);
    endtask

    initial begin
        rst                  = 1'b1;
        s_axis_tdata         = 8'h00;
        s_axis_tvalid        = 1'b0;
        s_axis_tlast         = 1'b0;
        s_axis_tuser         = 1'b0;
        cfg_local_mac        = LOCAL_MAC;
        cfg_promisc          = 1'b0;
        cfg_multicast_enable = 1'b0;
        last_dest            = '0;
        last_src             = '0;

        @(posedge clk);
        #2;
        chk("reset_hdr_valid", 64'(m_hdr_valid), 64'd0);
        chk("reset_dest", 64'(m_eth_dest_mac), 64'd0);
        chk("reset_pl_tvalid", 64'(m_payload_tvalid), 64'd0);
        chk("reset_err", 64'(error_header_early_termination), 64'd0);
        chk("reset_drop", 64'(rx_frame_dropped), 64'd0);
        rst = 1'b0;
        idle(2);

        // Unicast to our station, minimum-size payload.
        send_frame(LOCAL_MAC, SRC_A, 16'h0800, 46, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        idle(3);

        // Foreign unicast: dropped, header outputs keep the previous frame's fields.
        send_frame(OTHER_MAC, SRC_B, 16'h0806, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20);
        idle(2);
        chk("hold_dest_after_drop", 64'(m_eth_dest_mac), 64'(last_dest));
        chk("hold_src_after_drop", 64'(m_eth_src_mac), 64'(last_src));
        cfg_promisc = 1'b1;
        send_frame(OTHER_MAC, SRC_B, 16'h0806, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
        idle(2);
        cfg_promisc = 1'b0;

        // Group address filtering and broadcast.
        send_frame(MCAST_MAC, SRC_A, 16'h0800, 5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
        idle(2);
        cfg_multicast_enable = 1'b1;
        send_frame(MCAST_MAC, SRC_A, 16'h0800, 5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h50);
        idle(2);
        cfg_multicast_enable = 1'b0;
        send_frame(BCAST_MAC, SRC_B, 16'h0806, 4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h60);
        idle(2);

        // Truncated headers, including tlast on the final header byte.
        send_short(10, 8'hA0);
        idle(2);
        send_short(14, 8'hB0);
        idle(3);

        // Back-to-back frames; first has idle gaps, second flags a bad FCS on its last beat.
        send_frame(LOCAL_MAC, SRC_A, 16'h86DD, 8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h70);
        send_frame(BCAST_MAC, SRC_B, 16'h0800, 6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        idle(3);

        // Reset during payload byte 5, then the remaining bytes form a fresh frame.
        send_frame(LOCAL_MAC, SRC_B, 16'h0800, 5, 1'b0, 1'b1, 1'b0, 1'b1, 8'h90);
        send_byte(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("midrst_hdr_valid", 64'(m_hdr_valid), 64'd0);
        chk("midrst_dest", 64'(m_eth_dest_mac), 64'd0);
        chk("midrst_src", 64'(m_eth_src_mac), 64'd0);
        chk("midrst_type", 64'(m_eth_type), 64'd0);
        chk("midrst_pl_tvalid", 64'(m_payload_tvalid), 64'd0);
        chk("midrst_pl_tdata", 64'(m_payload_tdata), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(BCAST_MAC, SRC_A, 16'h0806, 4, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0);
        idle(5);

        chk("hdr_queue_drained", 64'(exp_hdr.size()), 64'd0);
        chk("pl_queue_drained", 64'(exp_pl.size()), 64'd0);
        chk("err_queue_drained", 64'(exp_err.size()), 64'd0);
        chk("drop_queue_drained", 64'(exp_drop.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
